// File: rtl/line_executor_pkg.sv
// Shared types and sizing for the line executor: sequencer states, opcodes
// and register-file geometry.
package line_executor_pkg;

    localparam int NUM_REGS   = 8;
    localparam int REG_IDX_W  = 3;
    localparam int LINE_BYTES = 4;
    localparam int MUL_CYCLES = 8;

    typedef enum logic [3:0] {
        SRST, SR1, SR2, SR3, SR4, SCALC, SWRITE, SNXT, SFINISH, SERR
    } SequencerState;

    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_ADD  = 8'h01,
        OP_SUB  = 8'h02,
        OP_AND  = 8'h03,
        OP_OR   = 8'h04,
        OP_XOR  = 8'h05,
        OP_LDI  = 8'h06,
        OP_MUL  = 8'h07,
        OP_JNZ  = 8'h08,
        OP_HALT = 8'hFF
    } Opcode;

    // Ops whose result lands in R[rd] during SWRITE.
    function automatic logic writes_rd(input logic [7:0] op);
        return (op >= OP_ADD) && (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/mul8_shift_add.sv
// Iterative 8x8 -> low-8 multiplier, one shift-add partial product per
// enabled cycle; product is valid combinationally in the cycle done is high.
module mul8_shift_add
    import line_executor_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] product,
    output logic       done
);

    logic [2:0] step_idx;
    logic [7:0] acc;
    logic [7:0] term;

    // The current step's term is folded in combinationally so the final
    // product is ready in the last step, without an extra cycle.
    assign term    = b[step_idx] ? (a << step_idx) : 8'h00;
    assign product = acc + term;
    assign done    = (step_idx == 3'(MUL_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_idx <= '0;
            acc      <= '0;
        end else if (clr) begin
            step_idx <= '0;
            acc      <= '0;
        end else if (en && !done) begin
            acc      <= product;
            step_idx <= step_idx + 3'd1;
        end
    end

endmodule

// File: rtl/line_executor.sv
// Fetch/execute datapath driven by the CPU sequencer state: fetches a 4-byte
// line, executes it, writes back, advances pc and reports line status strobes.
module line_executor
    import line_executor_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  SequencerState        q,
    output logic [7:0]           mem_addr,
    input  logic [7:0]           mem_rdata,
    output logic                 nxt_line,
    output logic                 finish,
    output logic                 err,
    output logic [7:0]           pc,
    input  logic [REG_IDX_W-1:0] dbg_sel,
    output logic [7:0]           dbg_data
);

    logic [7:0] regs [NUM_REGS];
    logic [7:0] op, rd, rs1, imm;
    logic [7:0] result;
    logic [7:0] src_a, src_b, alu_out, mul_product;
    logic       mul_done, done, bad, taken;
    logic       rd_bad, rs1_bad, rs2_bad;

    assign src_a    = regs[rs1[REG_IDX_W-1:0]];
    assign src_b    = regs[imm[REG_IDX_W-1:0]];
    assign dbg_data = regs[dbg_sel];

    assign rd_bad  = |rd[7:REG_IDX_W];
    assign rs1_bad = |rs1[7:REG_IDX_W];
    assign rs2_bad = |imm[7:REG_IDX_W];

    always_comb begin
        mem_addr = pc;
        unique case (q)
            SR2:     mem_addr = pc + 8'd1;
            SR3:     mem_addr = pc + 8'd2;
            SR4:     mem_addr = pc + 8'd3;
            default: mem_addr = pc;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        bad     = 1'b0;
        alu_out = 8'h00;
        case (op)
            OP_NOP, OP_HALT: bad = 1'b0;
            OP_LDI:  begin bad = rd_bad; alu_out = imm; end
            OP_JNZ:  bad = rd_bad;
            OP_ADD:  begin bad = rd_bad | rs1_bad | rs2_bad; alu_out = src_a + src_b; end
            OP_SUB:  begin bad = rd_bad | rs1_bad | rs2_bad; alu_out = src_a - src_b; end
            OP_AND:  begin bad = rd_bad | rs1_bad | rs2_bad; alu_out = src_a & src_b; end
            OP_OR:   begin bad = rd_bad | rs1_bad | rs2_bad; alu_out = src_a | src_b; end
            OP_XOR:  begin bad = rd_bad | rs1_bad | rs2_bad; alu_out = src_a ^ src_b; end
            OP_MUL:  begin bad = rd_bad | rs1_bad | rs2_bad; alu_out = mul_product; end
            default: bad = 1'b1;
        endcase
    end

    assign done     = (op == OP_MUL) ? mul_done : 1'b1;
    assign err      = (q == SCALC) && bad;
    assign finish   = (q == SCALC) && (op == OP_HALT) && !bad;
    assign nxt_line = (q == SCALC) && done && !bad && (op != OP_HALT);
    assign taken    = (op == OP_JNZ) && (regs[rd[REG_IDX_W-1:0]] != 8'h00);

    mul8_shift_add u_mul (
        .clk     (clk),
        .rst     (rst),
        .clr     (q != SCALC),
        .en      ((q == SCALC) && (op == OP_MUL)),
        .a       (src_a),
        .b       (src_b),
        .product (mul_product),
        .done    (mul_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= '0;
            op     <= '0;
            rd     <= '0;
            rs1    <= '0;
            imm    <= '0;
            result <= '0;
            // NOTE: the register file is reset here because its zero state is
            // architecturally visible; larger RAM-style arrays normally are not.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            case (q)
                SR1:     op  <= mem_rdata;
                SR2:     rd  <= mem_rdata;
                SR3:     rs1 <= mem_rdata;
                SR4:     imm <= mem_rdata;
                SCALC:   if (done) result <= alu_out;
                SWRITE:  if (writes_rd(op)) regs[rd[REG_IDX_W-1:0]] <= result;
                SNXT:    pc <= taken ? imm : pc + 8'(LINE_BYTES);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_executor.sv
// Scoreboard bench for line_executor: a sequencer-like driver runs programs
// from a bench ROM; a negedge monitor compares line strobes and probes.
module tb_line_executor;
    import line_executor_pkg::*;

    localparam logic [2:0] S_NXT = 3'b001;
    localparam logic [2:0] S_FIN = 3'b010;
    localparam logic [2:0] S_ERR = 3'b100;

    logic          clk = 1'b0;
    logic          rst;
    SequencerState q;
    logic [7:0]    mem_addr, mem_rdata, pc, dbg_data;
    logic          nxt_line, finish, err;
    logic [2:0]    dbg_sel;
    logic [7:0]    rom [256];

    assign mem_rdata = rom[mem_addr];
    always #5 clk = ~clk;

    line_executor dut (
        .clk(clk), .rst(rst), .q(q), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .nxt_line(nxt_line), .finish(finish), .err(err), .pc(pc),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    typedef struct { logic [2:0] strobes; logic [7:0] pc; int cycles; } line_exp_t;
    typedef struct { bit is_pc; logic [2:0] sel; logic [7:0] val; } probe_exp_t;

    line_exp_t  line_q[$];
    probe_exp_t probe_q[$];
    line_exp_t  le;
    probe_exp_t pe;
    int         vectors = 0;
    int         miscompares = 0;
    int         scalc_cnt = 0;
    bit         probe_req = 1'b0;
    logic [7:0] got;

    // Monitor: line status at each strobe, register/pc probes on request.
    always @(negedge clk) begin
        if (q == SCALC) scalc_cnt++;
        else            scalc_cnt = 0;
        if (q == SCALC && (nxt_line || finish || err)) begin
            vectors++;
            if (line_q.size() == 0) begin
                miscompares++;
                $display("FAIL line_unexpected: strobes(err,fin,nxt)=%b pc=%h", {err, finish, nxt_line}, pc);
            end else begin
                le = line_q.pop_front();
                if ({err, finish, nxt_line} !== le.strobes || pc !== le.pc || scalc_cnt != le.cycles) begin
                    miscompares++;
                    $display("FAIL line@%h: got strobes=%b pc=%h cycles=%0d, want strobes=%b pc=%h cycles=%0d",
                             le.pc, {err, finish, nxt_line}, pc, scalc_cnt, le.strobes, le.pc, le.cycles);
                end
            end
        end
        if (probe_req) begin
            vectors++;
            if (probe_q.size() == 0) begin
                miscompares++;
                $display("FAIL probe_underflow");
            end else begin
                pe  = probe_q.pop_front();
                got = pe.is_pc ? pc : dbg_data;
                if (got !== pe.val) begin
                    miscompares++;
                    if (pe.is_pc) $display("FAIL probe pc: got %h want %h", got, pe.val);
                    else          $display("FAIL probe R%0d: got %h want %h", pe.sel, got, pe.val);
                end
            end
        end
    end

    task automatic step(input SequencerState s);
        q = s;
        @(posedge clk); #1;
    endtask

    task automatic exp_line(input logic [2:0] s, input logic [7:0] p, input int c);
        line_exp_t e;
        e.strobes = s; e.pc = p; e.cycles = c;
        line_q.push_back(e);
    endtask

    task automatic probe(input bit is_pc, input logic [2:0] sel, input logic [7:0] val);
        probe_exp_t e;
        e.is_pc = is_pc; e.sel = sel; e.val = val;
        probe_q.push_back(e);
        dbg_sel   = sel;
        probe_req = 1'b1;
        @(posedge clk); #1;
        probe_req = 1'b0;
    endtask

    task automatic put(input logic [7:0] a, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] addr;
        addr = a;        rom[addr] = b0;
        addr = a + 8'd1; rom[addr] = b1;
        addr = a + 8'd2; rom[addr] = b2;
        addr = a + 8'd3; rom[addr] = b3;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q   = SRST;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step(SRST);
    endtask

    task automatic fetch();
        step(SR1); step(SR2); step(SR3); step(SR4);
    endtask

    // Sequencer model: fetch, hold SCALC until a strobe, then branch.
    task automatic run_line(output bit stop);
        logic [2:0] s;
        int n;
        fetch();
        q = SCALC;
        s = 3'b000;
        n = 0;
        while (n < 24 && s == 3'b000) begin
            @(negedge clk);
            s = {err, finish, nxt_line};
            @(posedge clk); #1;
            n++;
        end
        stop = 1'b1;
        if (s == 3'b000) begin
            vectors++;
            miscompares++;
            $display("FAIL scalc_timeout: no strobe after %0d cycles at pc=%h", n, pc);
            step(SRST);
        end else if (s[2]) step(SERR);
        else if (s[1])     step(SFINISH);
        else begin
            step(SWRITE);
            step(SNXT);
            stop = 1'b0;
        end
    endtask

    task automatic run_prog(input int max_lines);
        bit stop;
        for (int i = 0; i < max_lines; i++) begin
            run_line(stop);
            if (stop) break;
        end
        vectors++;
        if (line_q.size() != 0) begin
            miscompares++;
            $display("FAIL line_missing: %0d expected line events not seen", line_q.size());
            line_q.delete();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit stop;
        rst = 1'b0; q = SRST; dbg_sel = 3'd0;
        clear_rom();

        // Reset state
        do_reset();
        probe(1, 0, 8'h00);
        probe(0, 0, 8'h00);
        probe(0, 7, 8'h00);

        // LDI R1,5; LDI R2,7; ADD R3,R1,R2; HALT
        clear_rom(); do_reset();
        put(8'h00, 8'h06, 8'h01, 8'h00, 8'h05);
        put(8'h04, 8'h06, 8'h02, 8'h00, 8'h07);
        put(8'h08, 8'h01, 8'h03, 8'h01, 8'h02);
        put(8'h0C, 8'hFF, 8'h00, 8'h00, 8'h00);
        exp_line(S_NXT, 8'h00, 1); exp_line(S_NXT, 8'h04, 1);
        exp_line(S_NXT, 8'h08, 1); exp_line(S_FIN, 8'h0C, 1);
        run_prog(10);
        probe(0, 3, 8'h0C);
        probe(0, 1, 8'h05);
        probe(1, 0, 8'h0C);

        // MUL R4,R1,R2 with 13*21 = 273 -> 0x11, 8 SCALC cycles
        clear_rom(); do_reset();
        put(8'h00, 8'h06, 8'h01, 8'h00, 8'd13);
        put(8'h04, 8'h06, 8'h02, 8'h00, 8'd21);
        put(8'h08, 8'h07, 8'h04, 8'h01, 8'h02);
        put(8'h0C, 8'hFF, 8'h00, 8'h00, 8'h00);
        exp_line(S_NXT, 8'h00, 1); exp_line(S_NXT, 8'h04, 1);
        exp_line(S_NXT, 8'h08, 8); exp_line(S_FIN, 8'h0C, 1);
        run_prog(10);
        probe(0, 4, 8'h11);

        // Illegal opcode 0x42
        clear_rom(); do_reset();
        put(8'h00, 8'h06, 8'h01, 8'h00, 8'h09);
        put(8'h04, 8'h42, 8'h00, 8'h00, 8'h00);
        exp_line(S_NXT, 8'h00, 1); exp_line(S_ERR, 8'h04, 1);
        run_prog(10);
        probe(0, 1, 8'h09);
        probe(0, 0, 8'h00);
        probe(1, 0, 8'h04);

        // ADD R9,R1,R1 -> rd out of range
        clear_rom(); do_reset();
        put(8'h00, 8'h06, 8'h01, 8'h00, 8'h09);
        put(8'h04, 8'h01, 8'h09, 8'h01, 8'h01);
        exp_line(S_NXT, 8'h00, 1); exp_line(S_ERR, 8'h04, 1);
        run_prog(10);
        probe(0, 1, 8'h09);
        probe(1, 0, 8'h04);

        // XOR R2,R1,R8 -> rs2 out of range, R2 untouched
        clear_rom(); do_reset();
        put(8'h00, 8'h06, 8'h01, 8'h00, 8'h09);
        put(8'h04, 8'h05, 8'h02, 8'h01, 8'h08);
        exp_line(S_NXT, 8'h00, 1); exp_line(S_ERR, 8'h04, 1);
        run_prog(10);
        probe(0, 2, 8'h00);

        // Countdown loop: SUB runs 3 times, JNZ falls through on the third
        clear_rom(); do_reset();
        put(8'h00, 8'h06, 8'h05, 8'h00, 8'h01);
        put(8'h04, 8'h06, 8'h00, 8'h00, 8'h03);
        put(8'h08, 8'h02, 8'h00, 8'h00, 8'h05);
        put(8'h0C, 8'h08, 8'h00, 8'h00, 8'h08);
        put(8'h10, 8'hFF, 8'h00, 8'h00, 8'h00);
        exp_line(S_NXT, 8'h00, 1); exp_line(S_NXT, 8'h04, 1);
        for (int i = 0; i < 3; i++) begin
            exp_line(S_NXT, 8'h08, 1); exp_line(S_NXT, 8'h0C, 1);
        end
        exp_line(S_FIN, 8'h10, 1);
        run_prog(20);
        probe(0, 0, 8'h00);
        probe(1, 0, 8'h10);

        // pc wrap from 0xFC and a non-aligned jump target
        clear_rom(); do_reset();
        put(8'h00, 8'h08, 8'h01, 8'h00, 8'h10);
        put(8'h04, 8'h06, 8'h01, 8'h00, 8'h01);
        put(8'h08, 8'h08, 8'h01, 8'h00, 8'hFC);
        put(8'hFC, 8'h06, 8'h02, 8'h00, 8'hAA);
        put(8'h10, 8'h08, 8'h01, 8'h00, 8'h21);
        put(8'h21, 8'hFF, 8'h00, 8'h00, 8'h00);
        exp_line(S_NXT, 8'h00, 1); exp_line(S_NXT, 8'h04, 1);
        exp_line(S_NXT, 8'h08, 1); exp_line(S_NXT, 8'hFC, 1);
        exp_line(S_NXT, 8'h00, 1); exp_line(S_NXT, 8'h10, 1);
        exp_line(S_FIN, 8'h21, 1);
        run_prog(20);
        probe(0, 2, 8'hAA);
        probe(1, 0, 8'h21);

        // Reset in SCALC cycle 4 of a MUL, then rerun from 0x00
        clear_rom(); do_reset();
        put(8'h00, 8'h06, 8'h01, 8'h00, 8'd13);
        put(8'h04, 8'h06, 8'h02, 8'h00, 8'd21);
        put(8'h08, 8'h07, 8'h04, 8'h01, 8'h02);
        put(8'h0C, 8'hFF, 8'h00, 8'h00, 8'h00);
        exp_line(S_NXT, 8'h00, 1); exp_line(S_NXT, 8'h04, 1);
        run_line(stop);
        run_line(stop);
        fetch();
        q = SCALC;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        q   = SRST;
        probe(1, 0, 8'h00);
        probe(0, 1, 8'h00);
        probe(0, 2, 8'h00);
        rst = 1'b0;
        step(SRST);
        exp_line(S_NXT, 8'h00, 1); exp_line(S_NXT, 8'h04, 1);
        exp_line(S_NXT, 8'h08, 8); exp_line(S_FIN, 8'h0C, 1);
        run_prog(10);
        probe(0, 4, 8'h11);
        probe(1, 0, 8'h0C);

        // Wraparound arithmetic and logic ops
        clear_rom(); do_reset();
        put(8'h00, 8'h06, 8'h01, 8'h00, 8'h01);
        put(8'h04, 8'h02, 8'h02, 8'h00, 8'h01);
        put(8'h08, 8'h03, 8'h05, 8'h02, 8'h01);
        put(8'h0C, 8'h06, 8'h03, 8'h00, 8'h3C);
        put(8'h10, 8'h04, 8'h06, 8'h03, 8'h01);
        put(8'h14, 8'h05, 8'h07, 8'h03, 8'h02);
        put(8'h18, 8'h01, 8'h02, 8'h02, 8'h01);
        put(8'h20, 8'hFF, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) exp_line(S_NXT, 8'(i * 4), 1);
        exp_line(S_FIN, 8'h20, 1);
        run_prog(20);
        probe(0, 5, 8'h01);
        probe(0, 6, 8'h3D);
        probe(0, 7, 8'hC3);
        probe(0, 2, 8'h00);
        probe(0, 0, 8'h00);
        probe(1, 0, 8'h20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
